// File: rtl/loproc_mul_ctrl.sv
// Sequencing front-end for the LoPROC shift-add multiplier: sign/magnitude
// conversion, launch, product capture with sign fix-up, flush and timeout handling.
module loproc_mul_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  mul_clk,
    input  logic                  mul_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] mul_in1,
    output logic [DATA_WIDTH-1:0] mul_in2,
    output logic                  mul_valid_in,
    input  logic [DATA_WIDTH-1:0] mul_out_l,
    input  logic [DATA_WIDTH-1:0] mul_out_h,
    input  logic                  mul_valid_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  err_timeout
);

    // state | meaning
    // IDLE  | ready for a request
    // ISSUE | launch pulse to the multiplier
    // WAIT  | multiplier iterating, watchdog running
    // RESP  | result held until writeback takes it
    // DRAIN | waiting out an abandoned multiply
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [W-1:0]   ONE_W    = W'(1);
    localparam logic [2*W-1:0] ONE_P    = (2*W)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [1:0]     op_q;
    logic           neg_q;
    logic           issue_q;
    logic [CW-1:0]  wait_cnt;
    logic           cnt_tc;
    logic           a_signed;
    logic           b_signed;
    logic           neg_in;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   result;
    logic           timeout_hit;

    assign a_signed = (req_op == 2'b01) || (req_op == 2'b10);
    assign b_signed = (req_op == 2'b01);
    assign neg_in   = (a_signed & req_a[W-1]) ^ (b_signed & req_b[W-1]);
    assign mag_a    = (a_signed & req_a[W-1]) ? (~req_a + ONE_W) : req_a;
    assign mag_b    = (b_signed & req_b[W-1]) ? (~req_b + ONE_W) : req_b;

    assign prod     = {mul_out_h, mul_out_l};
    assign prod_fix = neg_q ? (~prod + ONE_P) : prod;
    assign result   = (op_q == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];

    assign cnt_tc      = (wait_cnt == '0);
    assign timeout_hit = (state == S_WAIT) && !flush && !mul_valid_out && cnt_tc;

    // A flush arriving during ISSUE must suppress the launch, otherwise a stale
    // product would land in the WAIT of the next request.
    assign mul_valid_in = issue_q & ~flush;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req_valid) state_nx = S_ISSUE;
            S_ISSUE: state_nx = flush ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (flush)              state_nx = mul_valid_out ? S_IDLE : S_DRAIN;
                else if (mul_valid_out) state_nx = S_RESP;
                else if (cnt_tc)        state_nx = S_DRAIN;
            end
            S_RESP:  if (flush || rsp_ready) state_nx = S_IDLE;
            // The done pulse always ends DRAIN; holding on flush here could never recover.
            S_DRAIN: if (mul_valid_out) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge mul_clk or posedge mul_rst) begin
        if (mul_rst) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            issue_q     <= 1'b0;
            op_q        <= 2'b00;
            neg_q       <= 1'b0;
            mul_in1     <= '0;
            mul_in2     <= '0;
            wait_cnt    <= '0;
            rsp_data    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state     <= state_nx;
            req_ready <= (state_nx == S_IDLE);
            rsp_valid <= (state_nx == S_RESP);
            issue_q   <= (state_nx == S_ISSUE);

            if (state == S_IDLE && req_valid) begin
                op_q    <= req_op;
                neg_q   <= neg_in;
                mul_in1 <= mag_a;
                mul_in2 <= mag_b;
            end

            if (state == S_ISSUE)
                wait_cnt <= CNT_LOAD;
            else if (state == S_WAIT && !cnt_tc)
                wait_cnt <= wait_cnt - CNT_ONE;

            if (state == S_WAIT && !flush && mul_valid_out)
                rsp_data <= result;

            if (timeout_hit)
                err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_loproc_mul_ctrl.sv
// Directed bench for loproc_mul_ctrl with a behavioural shift-add multiplier model.
module tb_loproc_mul_ctrl;

    logic        mul_clk = 1'b0;
    logic        mul_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        flush = 1'b0;
    logic [31:0] mul_in1;
    logic [31:0] mul_in2;
    logic        mul_valid_in;
    logic [31:0] mul_out_l = '0;
    logic [31:0] mul_out_h = '0;
    logic        mul_valid_out = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        err_timeout;

    int n_chk = 0;
    int n_err = 0;

    loproc_mul_ctrl #(.DATA_WIDTH(32), .TIMEOUT(64)) dut (
        .mul_clk(mul_clk), .mul_rst(mul_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_valid_in(mul_valid_in),
        .mul_out_l(mul_out_l), .mul_out_h(mul_out_h), .mul_valid_out(mul_valid_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .err_timeout(err_timeout)
    );

    always #5 mul_clk = ~mul_clk;

    // Multiplier model: launch seen on the edge, done pulse driven mid-cycle.
    logic [63:0] prod_pend = '0;
    int          lat_cnt = 0;
    bit          stub = 1'b0;
    int          kick_req = 0;
    int          kick_ack = 0;

    always @(posedge mul_clk) begin
        if (mul_valid_in && !stub) begin
            prod_pend = 64'(mul_in1) * 64'(mul_in2);
            if (mul_in1 == 0 || mul_in2 == 0) lat_cnt = 1;
            else if ($countones(mul_in2) < 2) lat_cnt = 2;
            else lat_cnt = $countones(mul_in2);
        end
    end

    always @(negedge mul_clk) begin
        mul_valid_out = 1'b0;
        mul_out_l     = '0;
        mul_out_h     = '0;
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                mul_valid_out = 1'b1;
                mul_out_l     = prod_pend[31:0];
                mul_out_h     = prod_pend[63:32];
            end
        end
        if (kick_req != kick_ack) begin
            kick_ack      = kick_req;
            mul_valid_out = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_in1,
                          input logic [31:0] exp_in2, input logic [31:0] exp_rsp);
        int n;
        @(negedge mul_clk);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        @(negedge mul_clk);
        req_valid = 1'b0;
        chk({tag, "_launch"}, 64'(mul_valid_in), 64'd1);
        chk({tag, "_in1"}, 64'(mul_in1), 64'(exp_in1));
        chk({tag, "_in2"}, 64'(mul_in2), 64'(exp_in2));
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge mul_clk);
            n++;
        end
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_data"}, 64'(rsp_data), 64'(exp_rsp));
        @(negedge mul_clk);
    endtask

    initial begin
        int  n;
        bit  bad;

        repeat (3) @(negedge mul_clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_valid_in", 64'(mul_valid_in), 64'd0);
        chk("rst_in1", 64'(mul_in1), 64'd0);
        chk("rst_in2", 64'(mul_in2), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        mul_rst = 1'b0;
        @(negedge mul_clk);

        run_op("mul_7x6",     2'b00, 32'd7,        32'd6,        32'd7,        32'd6,        32'd42);
        run_op("mulh_m3x5",   2'b01, 32'hFFFFFFFD, 32'd5,        32'd3,        32'd5,        32'hFFFFFFFF);
        run_op("mul_m3x5",    2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1);
        run_op("mulhu_max",   2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mulh_min2",   2'b01, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mulhsu_m1",   2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mulh_minmax", 2'b01, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000);
        run_op("mulhu_big",   2'b11, 32'h80000000, 32'd2,        32'h80000000, 32'd2,        32'd1);
        run_op("mulh_5xm3",   2'b01, 32'd5,        32'hFFFFFFFD, 32'd5,        32'd3,        32'hFFFFFFFF);

        // Zero operand: exact cycle timing, rsp_ready held high.
        @(negedge mul_clk);
        req_valid = 1'b1; req_op = 2'b00; req_a = 32'd0; req_b = 32'd123;
        @(negedge mul_clk);                        // T1
        req_valid = 1'b0;
        chk("zero_t1_launch", 64'(mul_valid_in), 64'd1);
        chk("zero_t1_ready", 64'(req_ready), 64'd0);
        @(negedge mul_clk);                        // T2
        chk("zero_t2_pulse_end", 64'(mul_valid_in), 64'd0);
        chk("zero_t2_rsp", 64'(rsp_valid), 64'd0);
        @(negedge mul_clk);                        // T3
        chk("zero_t3_rsp", 64'(rsp_valid), 64'd1);
        chk("zero_t3_data", 64'(rsp_data), 64'd0);
        chk("zero_t3_ready", 64'(req_ready), 64'd0);
        @(negedge mul_clk);                        // T4
        chk("zero_t4_ready", 64'(req_ready), 64'd1);
        chk("zero_t4_rsp", 64'(rsp_valid), 64'd0);

        // Flush during WAIT: popcount(0xFFFF)=16 so done lands in T17, IDLE at T18.
        @(negedge mul_clk);
        req_valid = 1'b1; req_op = 2'b11; req_a = 32'h1234; req_b = 32'hFFFF;
        @(negedge mul_clk);                        // T1
        req_valid = 1'b0;
        @(negedge mul_clk);                        // T2
        flush = 1'b1;
        @(negedge mul_clk);                        // T3
        flush = 1'b0;
        bad = 1'b0;
        for (int i = 3; i <= 17; i++) begin
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
            if (i < 17) @(negedge mul_clk);
        end
        chk("flush_wait_blocked", 64'(bad), 64'd0);
        @(negedge mul_clk);                        // T18
        chk("flush_wait_ready", 64'(req_ready), 64'd1);
        chk("flush_wait_no_rsp", 64'(rsp_valid), 64'd0);
        run_op("after_flush", 2'b00, 32'd2, 32'd3, 32'd2, 32'd3, 32'd6);

        // Flush during ISSUE suppresses the launch pulse.
        @(negedge mul_clk);
        req_valid = 1'b1; req_op = 2'b00; req_a = 32'd4; req_b = 32'd5;
        @(negedge mul_clk);                        // T1
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_issue_no_launch", 64'(mul_valid_in), 64'd0);
        @(negedge mul_clk);
        flush = 1'b0;
        chk("flush_issue_ready", 64'(req_ready), 64'd1);
        run_op("after_flush_issue", 2'b00, 32'd9, 32'd10, 32'd9, 32'd10, 32'd90);

        // Writeback stall: response held for 10 cycles.
        rsp_ready = 1'b0;
        @(negedge mul_clk);
        req_valid = 1'b1; req_op = 2'b00; req_a = 32'd9; req_b = 32'd9;
        @(negedge mul_clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge mul_clk);
            n++;
        end
        chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge mul_clk);
            if (rsp_data !== 32'd81 || req_ready !== 1'b0 || rsp_valid !== 1'b1) bad = 1'b1;
        end
        chk("stall_hold", 64'(bad), 64'd0);
        chk("stall_data", 64'(rsp_data), 64'd81);
        rsp_ready = 1'b1;
        @(negedge mul_clk);
        chk("stall_release_rsp", 64'(rsp_valid), 64'd0);
        chk("stall_release_ready", 64'(req_ready), 64'd1);

        // Dead multiplier: 64 WAIT cycles (T2..T65) then err_timeout from T66.
        stub = 1'b1;
        @(negedge mul_clk);
        req_valid = 1'b1; req_op = 2'b00; req_a = 32'd3; req_b = 32'd3;
        @(negedge mul_clk);                        // T1
        req_valid = 1'b0;
        repeat (64) @(negedge mul_clk);            // T65
        chk("timeout_not_yet", 64'(err_timeout), 64'd0);
        @(negedge mul_clk);                        // T66
        chk("timeout_set", 64'(err_timeout), 64'd1);
        chk("timeout_drain_ready", 64'(req_ready), 64'd0);
        chk("timeout_no_rsp", 64'(rsp_valid), 64'd0);
        kick_req++;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge mul_clk);
            n++;
        end
        chk("drain_exit_ready", 64'(req_ready), 64'd1);
        stub = 1'b0;
        run_op("after_timeout", 2'b00, 32'd2, 32'd3, 32'd2, 32'd3, 32'd6);
        chk("timeout_sticky", 64'(err_timeout), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
